// File: rtl/conv_1x1_mac_seq_pkg.sv
// Shared constants for the 1x1 convolution MAC block: FSM encodings, FP zero, width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_1x1_mac_seq_pkg;

  // FSM state encodings
  localparam logic [2:0] LOAD_W   = 3'd0;
  localparam logic [2:0] FILL     = 3'd1;
  localparam logic [2:0] MUL      = 3'd2;
  localparam logic [2:0] WAIT_MUL = 3'd3;
  localparam logic [2:0] ADD      = 3'd4;
  localparam logic [2:0] WAIT_ADD = 3'd5;
  localparam logic [2:0] OUT      = 3'd6;

  // IEEE-754 single +0.0
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Counter width for n states, never less than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_1x1_mac_weight_ram.sv
// Weight (and optional bias) store: one write port, one combinational read port.
// Latency: write visible on the cycle after we; read is same-cycle.
// Backpressure: none; always accepts writes.
module conv_1x1_mac_weight_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are not reset; the load phase always rewrites every word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fp_add.sv
// IEEE-754 single add (denormals flushed to zero, truncating rounding).
// Latency: 1 cycle valid_in -> valid_out.
// Backpressure: none; caller keeps at most one operation in flight.
module fp_add (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  output logic [31:0] result
);

  logic        a_ge;
  logic [31:0] big, sml;
  logic [7:0]  e_big, e_sml;
  logic [26:0] m_big, m_sml, diff, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic        found;
  logic [31:0] res;
  logic        add_unused;

  // Align smaller operand to larger, add or subtract magnitudes, renormalise
  always_comb begin
    a_ge  = (a[30:0] >= b[30:0]);
    big   = a_ge ? a : b;
    sml   = a_ge ? b : a;
    e_big = big[30:23];
    e_sml = sml[30:23];
    m_big = {1'b1, big[22:0], 3'b000};
    m_sml = {1'b1, sml[22:0], 3'b000} >> (e_big - e_sml);
    sum   = {1'b0, m_big} + {1'b0, m_sml};
    diff  = m_big - m_sml;
    lz    = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && diff[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    norm       = diff << lz;
    add_unused = ^{sum[2:0], norm[26], norm[2:0]};
    if (e_big == '0) begin
      res = 32'h0;
    end else if (e_sml == '0) begin
      res = big;
    end else if (big[31] == sml[31]) begin
      if (sum[27])
        res = (e_big == 8'hFE) ? {big[31], 8'hFF, 23'h0} : {big[31], e_big + 8'd1, sum[26:4]};
      else
        res = {big[31], e_big, sum[25:3]};
    end else if (diff == '0) begin
      res = 32'h0;
    end else if ({3'b000, lz} >= e_big) begin
      res = {big[31], 31'h0};
    end else begin
      res = {big[31], e_big - {3'b000, lz}, norm[25:3]};
    end
  end

  // Output register and valid pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      result    <= 32'h0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) result <= res;
    end
  end

endmodule

// File: rtl/fp_mul.sv
// IEEE-754 single multiply (denormals flushed to zero, truncating rounding).
// Latency: 1 cycle valid_in -> valid_out.
// Backpressure: none; caller keeps at most one operation in flight.
module fp_mul (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  output logic [31:0] result
);

  logic [47:0]       prod;
  logic signed [9:0] exp_s;
  logic [22:0]       mant;
  logic              sign;
  logic [31:0]       res;
  logic              mul_unused;

  // Combinational product, exponent and normalisation
  always_comb begin
    prod       = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp_s      = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(prod[47]);
    sign       = a[31] ^ b[31];
    mant       = prod[47] ? prod[46:24] : prod[45:23];
    mul_unused = ^prod[22:0];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      res = {sign, 31'h0};
    end else if (exp_s <= 10'sd0) begin
      res = {sign, 31'h0};
    end else if (exp_s >= 10'sd255) begin
      res = {sign, 8'hFF, 23'h0};
    end else begin
      res = {sign, exp_s[7:0], mant};
    end
  end

  // Output register and valid pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      result    <= 32'h0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) result <= res;
    end
  end

endmodule

// File: rtl/conv_1x1_mac_seq.sv
// 1x1 convolution: per pixel, CHANNEL_NUM_OUT serial dot products over CHANNEL_NUM_IN channels; bias via CONV_1X1_MAC_BIAS_EN.
// Latency: CHANNEL_NUM_OUT*(CHANNEL_NUM_IN*(Lmul+Ladd+2)+1) cycles from last input word to last result.
// Backpressure: in_ready low outside FILL; words offered while low are dropped; outputs cannot be stalled.
module conv_1x1_mac_seq
  import conv_1x1_mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 7,
  parameter int WEIGHT_NUM      = CHANNEL_NUM_IN * CHANNEL_NUM_OUT,
  parameter int CIN_WIDTH       = clog2_min1(CHANNEL_NUM_IN),
  parameter int COUT_WIDTH      = clog2_min1(CHANNEL_NUM_OUT),
  parameter int W_PTR_WIDTH     = clog2_min1(WEIGHT_NUM + CHANNEL_NUM_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_weight_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic                  weights_loaded,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  last_out
);

`ifdef CONV_1X1_MAC_BIAS_EN
  localparam int LOAD_NUM = WEIGHT_NUM + CHANNEL_NUM_OUT;
`else
  localparam int LOAD_NUM = WEIGHT_NUM;
`endif
  localparam logic [W_PTR_WIDTH-1:0] LOAD_LAST = W_PTR_WIDTH'(LOAD_NUM - 1);

  logic [2:0]             state;
  logic [W_PTR_WIDTH-1:0] w_ptr;
  logic [CIN_WIDTH-1:0]   cin_cnt;
  logic [COUT_WIDTH-1:0]  cout_cnt;
  logic [DATA_WIDTH-1:0]  acc, prod, acc_init;
  logic [DATA_WIDTH-1:0]  pix_mem [CHANNEL_NUM_IN];
  logic [W_PTR_WIDTH-1:0] mac_addr, w_raddr;
  logic [DATA_WIDTH-1:0]  w_rdata;
  logic                   cin_last, cout_last;
  logic                   mul_done, add_done;
  logic [31:0]            mul_res, add_res;

  assign cin_last  = (cin_cnt == CIN_WIDTH'(CHANNEL_NUM_IN - 1));
  assign cout_last = (cout_cnt == COUT_WIDTH'(CHANNEL_NUM_OUT - 1));
  assign mac_addr  = W_PTR_WIDTH'(cout_cnt) * W_PTR_WIDTH'(CHANNEL_NUM_IN) + W_PTR_WIDTH'(cin_cnt);
  assign in_ready  = (state == FILL);

`ifdef CONV_1X1_MAC_BIAS_EN
  logic [COUT_WIDTH-1:0] init_cout;
  // Outside MUL the read port fetches the bias for the output channel about to start
  assign init_cout = (state == OUT) ? cout_cnt + COUT_WIDTH'(1) : '0;
  assign w_raddr   = (state == MUL) ? mac_addr : W_PTR_WIDTH'(WEIGHT_NUM) + W_PTR_WIDTH'(init_cout);
  assign acc_init  = w_rdata;
`else
  assign w_raddr   = mac_addr;
  assign acc_init  = FP_ZERO;
`endif

  conv_1x1_mac_weight_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (LOAD_NUM),
    .ADDR_WIDTH (W_PTR_WIDTH)
  ) u_weight_ram (
    .clk   (clk),
    .we    ((state == LOAD_W) && valid_weight_in),
    .waddr (w_ptr),
    .wdata (weight_in),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  fp_mul u_fp_mul (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (state == MUL),
    .a         (pix_mem[cin_cnt]),
    .b         (w_rdata),
    .valid_out (mul_done),
    .result    (mul_res)
  );

  fp_add u_fp_add (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (state == ADD),
    .a         (acc),
    .b         (prod),
    .valid_out (add_done),
    .result    (add_res)
  );

  // Capture one pixel's channel vector while filling
  always_ff @(posedge clk) begin
    if (state == FILL && valid_in) pix_mem[cin_cnt] <= pxl_in;
  end

  // Control FSM: load weights, fill pixel, then one product in flight at a time
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= LOAD_W;
      w_ptr          <= '0;
      cin_cnt        <= '0;
      cout_cnt       <= '0;
      acc            <= FP_ZERO;
      prod           <= FP_ZERO;
      weights_loaded <= 1'b0;
      pxl_out        <= '0;
      valid_out      <= 1'b0;
      last_out       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      case (state)
        LOAD_W: if (valid_weight_in) begin
          if (w_ptr == LOAD_LAST) begin
            w_ptr          <= '0;
            weights_loaded <= 1'b1;
            state          <= FILL;
          end else begin
            w_ptr <= w_ptr + W_PTR_WIDTH'(1);
          end
        end
        FILL: if (valid_in) begin
          if (cin_last) begin
            cin_cnt  <= '0;
            cout_cnt <= '0;
            acc      <= acc_init;
            state    <= MUL;
          end else begin
            cin_cnt <= cin_cnt + CIN_WIDTH'(1);
          end
        end
        MUL: state <= WAIT_MUL;
        WAIT_MUL: if (mul_done) begin
          prod  <= mul_res;
          state <= ADD;
        end
        ADD: state <= WAIT_ADD;
        WAIT_ADD: if (add_done) begin
          acc <= add_res;
          if (!cin_last) begin
            cin_cnt <= cin_cnt + CIN_WIDTH'(1);
            state   <= MUL;
          end else begin
            state <= OUT;
          end
        end
        OUT: begin
          pxl_out   <= acc;
          valid_out <= 1'b1;
          last_out  <= cout_last;
          cin_cnt   <= '0;
          if (cout_last) begin
            state <= FILL;
          end else begin
            cout_cnt <= cout_cnt + COUT_WIDTH'(1);
            acc      <= acc_init;
            state    <= MUL;
          end
        end
        default: state <= LOAD_W;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_1x1_mac_seq.sv
// Directed bench for conv_1x1_mac_seq: 2x2 instance and 1x1 degenerate instance.
// Latency: expected results waited for with a bounded cycle budget.
// Backpressure: pixel words offered only while in_ready is high, except deliberate drop tests.
module tb_conv_1x1_mac_seq;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_valid_weight_in, a_weights_loaded, a_valid_in, a_in_ready, a_valid_out, a_last_out;
  logic [31:0] a_weight_in, a_pxl_in, a_pxl_out;
  logic        b_valid_weight_in, b_weights_loaded, b_valid_in, b_in_ready, b_valid_out, b_last_out;
  logic [31:0] b_weight_in, b_pxl_in, b_pxl_out;

  int tests  = 0;
  int failed = 0;

  logic [31:0] wa [6];
  logic [31:0] wb [2];

`ifdef CONV_1X1_MAC_BIAS_EN
  localparam int          A_LOAD = 6;
  localparam int          B_LOAD = 2;
  localparam logic [31:0] E_P1_O0 = 32'h40800000;  // 1 + 1*1 + 2*1
  localparam logic [31:0] E_P1_O1 = 32'h40C00000;  // -1 + 3*1 + 4*1
  localparam logic [31:0] E_P2_O0 = 32'h40400000;  // 1 + 1*2 + 2*0
  localparam logic [31:0] E_P2_O1 = 32'h40A00000;  // -1 + 3*2 + 4*0
  localparam logic [31:0] E_B     = 32'h40E00000;  // 1 + 2*3
`else
  localparam int          A_LOAD = 4;
  localparam int          B_LOAD = 1;
  localparam logic [31:0] E_P1_O0 = 32'h40400000;  // 1*1 + 2*1
  localparam logic [31:0] E_P1_O1 = 32'h40E00000;  // 3*1 + 4*1
  localparam logic [31:0] E_P2_O0 = 32'h40000000;  // 1*2 + 2*0
  localparam logic [31:0] E_P2_O1 = 32'h40C00000;  // 3*2 + 4*0
  localparam logic [31:0] E_B     = 32'h40C00000;  // 2*3
`endif

  conv_1x1_mac_seq #(.CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2)) u_dut_a (
    .clk             (clk),
    .reset           (reset),
    .valid_weight_in (a_valid_weight_in),
    .weight_in       (a_weight_in),
    .weights_loaded  (a_weights_loaded),
    .valid_in        (a_valid_in),
    .pxl_in          (a_pxl_in),
    .in_ready        (a_in_ready),
    .pxl_out         (a_pxl_out),
    .valid_out       (a_valid_out),
    .last_out        (a_last_out)
  );

  conv_1x1_mac_seq #(.CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(1)) u_dut_b (
    .clk             (clk),
    .reset           (reset),
    .valid_weight_in (b_valid_weight_in),
    .weight_in       (b_weight_in),
    .weights_loaded  (b_weights_loaded),
    .valid_in        (b_valid_in),
    .pxl_in          (b_pxl_in),
    .in_ready        (b_in_ready),
    .pxl_out         (b_pxl_out),
    .valid_out       (b_valid_out),
    .last_out        (b_last_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input bit junk_pixels);
    for (int i = 0; i < A_LOAD; i++) begin
      if (i == 2) begin
        chk("midload_weights_loaded", 32'(a_weights_loaded), 32'd0);
        chk("midload_in_ready", 32'(a_in_ready), 32'd0);
      end
      a_valid_weight_in = 1'b1;
      a_weight_in       = wa[i];
      a_valid_in        = junk_pixels;
      a_pxl_in          = 32'h7F7FFFFF;
      tick();
    end
    a_valid_weight_in = 1'b0;
    a_valid_in        = 1'b0;
    chk("loaded_weights_loaded", 32'(a_weights_loaded), 32'd1);
    chk("loaded_in_ready", 32'(a_in_ready), 32'd1);
  endtask

  task automatic send_a(input logic [31:0] p0, input logic [31:0] p1);
    logic [31:0] p [2];
    int n;
    p[0] = p0;
    p[1] = p1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!a_in_ready && n < 300) begin
        tick();
        n++;
      end
      chk("send_in_ready", 32'(a_in_ready), 32'd1);
      a_valid_in = 1'b1;
      a_pxl_in   = p[k];
      tick();
      a_valid_in = 1'b0;
    end
  endtask

  task automatic expect_a(input string tag, input logic [31:0] d, input logic l, input logic r);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (a_valid_out) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_pxl_out"}, a_pxl_out, d);
      chk({tag, "_last_out"}, 32'(a_last_out), 32'(l));
      chk({tag, "_in_ready"}, 32'(a_in_ready), 32'(r));
    end
  endtask

  initial begin
    bit seen;
    wa[0] = 32'h3F800000; wa[1] = 32'h40000000; wa[2] = 32'h40400000;
    wa[3] = 32'h40800000; wa[4] = 32'h3F800000; wa[5] = 32'hBF800000;
    wb[0] = 32'h40000000; wb[1] = 32'h3F800000;
    reset = 1'b1;
    a_valid_weight_in = 1'b0; a_weight_in = '0; a_valid_in = 1'b0; a_pxl_in = '0;
    b_valid_weight_in = 1'b0; b_weight_in = '0; b_valid_in = 1'b0; b_pxl_in = '0;
    tick();
    tick();

    // reset state
    chk("rst_weights_loaded", 32'(a_weights_loaded), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_valid_out", 32'(a_valid_out), 32'd0);
    chk("rst_last_out", 32'(a_last_out), 32'd0);
    chk("rst_pxl_out", a_pxl_out, 32'd0);
    reset = 1'b0;
    tick();

    // weights load with junk pixel strobes that must be dropped
    load_a(1'b1);

    // pixel 1, then junk pixel and weight strobes while computing
    send_a(32'h3F800000, 32'h3F800000);
    for (int i = 0; i < 6; i++) begin
      a_valid_in        = 1'b1;
      a_pxl_in          = 32'h7F7FFFFF;
      a_valid_weight_in = 1'b1;
      a_weight_in       = 32'h7F7FFFFF;
      tick();
    end
    chk("busy_in_ready", 32'(a_in_ready), 32'd0);
    a_valid_in        = 1'b0;
    a_valid_weight_in = 1'b0;
    expect_a("p1_o0", E_P1_O0, 1'b0, 1'b0);
    expect_a("p1_o1", E_P1_O1, 1'b1, 1'b1);
    @(negedge clk);
    chk("p1_pulse_valid_out", 32'(a_valid_out), 32'd0);
    chk("p1_hold_pxl_out", a_pxl_out, E_P1_O1);

    // back-to-back second pixel
    send_a(32'h40000000, 32'h00000000);
    expect_a("p2_o0", E_P2_O0, 1'b0, 1'b0);
    expect_a("p2_o1", E_P2_O1, 1'b1, 1'b1);

    // reset while the first accumulation is in WAIT_ADD
    send_a(32'h3F800000, 32'h3F800000);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_valid_out", 32'(a_valid_out), 32'd0);
    chk("midrst_weights_loaded", 32'(a_weights_loaded), 32'd0);
    chk("midrst_in_ready", 32'(a_in_ready), 32'd0);
    reset = 1'b0;
    tick();
    load_a(1'b0);
    send_a(32'h3F800000, 32'h3F800000);
    expect_a("rl_o0", E_P1_O0, 1'b0, 1'b0);
    expect_a("rl_o1", E_P1_O1, 1'b1, 1'b1);

    // degenerate 1x1 instance
    for (int i = 0; i < B_LOAD; i++) begin
      b_valid_weight_in = 1'b1;
      b_weight_in       = wb[i];
      tick();
    end
    b_valid_weight_in = 1'b0;
    chk("b_weights_loaded", 32'(b_weights_loaded), 32'd1);
    chk("b_in_ready", 32'(b_in_ready), 32'd1);
    b_valid_in = 1'b1;
    b_pxl_in   = 32'h40400000;
    tick();
    b_valid_in = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (b_valid_out) seen = 1'b1;
    end
    chk("b_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("b_pxl_out", b_pxl_out, E_B);
      chk("b_last_out", 32'(b_last_out), 32'd1);
    end
    @(negedge clk);
    chk("b_pulse_valid_out", 32'(b_valid_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
